// File: rtl/jk_motion_if.sv
// jk_motion_if: key levels and collision flags into the motion controller,
// character position / sprite state back out to the renderers.
interface jk_motion_if #(
  parameter int unsigned POS_W = 12,
  parameter int unsigned LVL_W = 3
);
  logic             key_space;
  logic             key_left;
  logic             key_right;
  logic             col_left;
  logic             col_right;
  logic             col_top;
  logic             col_bot;
  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;
  logic [2:0]       skin;
  logic             facing;
  logic [LVL_W-1:0] level;

  modport master (
    output key_space, key_left, key_right, col_left, col_right, col_top, col_bot,
    input  pos_x, pos_y, skin, facing, level
  );

  modport slave (
    input  key_space, key_left, key_right, col_left, col_right, col_top, col_bot,
    output pos_x, pos_y, skin, facing, level
  );
endinterface

// File: rtl/jk_motion_ctl.sv
// jk_motion_ctl: platformer character motion (walk, charged jump, gravity, level paging).
// Optional JK_WALL_BOUNCE_EN: an airborne wall hit reflects vx instead of cancelling it.
module jk_motion_ctl #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned TICK_HZ      = 100,
  parameter int unsigned POS_W        = 12,
  parameter int unsigned FRAC         = 4,
  parameter int unsigned VEL_W        = 10,
  parameter int unsigned SCREEN_H     = 600,
  parameter int unsigned CHAR_H       = 63,
  parameter int unsigned X_START      = 70,
  parameter int unsigned Y_START      = 473,
  parameter int unsigned HSTEP        = 3,
  parameter int unsigned GRAVITY      = 4,
  parameter int unsigned VY_MAX_FALL  = 160,
  parameter int unsigned CHARGE_STEP  = 8,
  parameter int unsigned CHARGE_TICKS = 3,
  parameter int unsigned VJ_MAX       = 160,
  parameter int unsigned TOP_MARGIN   = 5,
  parameter int unsigned NUM_LEVELS   = 5
) (
  input  logic       clk,
  input  logic       rst,
  jk_motion_if.slave bus
);
  localparam int unsigned TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CP_W     = (CHARGE_TICKS > 1) ? $clog2(CHARGE_TICKS) : 1;
  localparam int unsigned LVL_W    = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int unsigned ACC_W    = POS_W + FRAC;
  localparam int unsigned SUM_W    = ACC_W + 1;
  localparam int unsigned VEL_W1   = VEL_W + 1;

  localparam logic signed [SUM_W-1:0] HSTEP_FX   = SUM_W'(HSTEP << FRAC);
  localparam logic signed [SUM_W-1:0] X_MAX_FX   = SUM_W'(((1 << POS_W) - 1) << FRAC);
  localparam logic signed [SUM_W-1:0] TOP_FX     = SUM_W'(TOP_MARGIN << FRAC);
  localparam logic signed [SUM_W-1:0] BOT_LIM_FX = SUM_W'((SCREEN_H - CHAR_H + 1) << FRAC);
  localparam logic [ACC_W-1:0] Y_FLOOR   = ACC_W'((SCREEN_H - CHAR_H) << FRAC);
  localparam logic [ACC_W-1:0] Y_WRAP_UP = ACC_W'((SCREEN_H - CHAR_H - TOP_MARGIN) << FRAC);
  localparam logic [ACC_W-1:0] Y_WRAP_DN = ACC_W'(TOP_MARGIN << FRAC);
  localparam logic [ACC_W-1:0] X_RST     = ACC_W'(X_START << FRAC);
  localparam logic [ACC_W-1:0] Y_RST     = ACC_W'(Y_START << FRAC);
  localparam logic [ACC_W-1:0] INT_MASK  = ~ACC_W'((1 << FRAC) - 1);
  localparam logic signed [VEL_W1-1:0] GRAV_S   = VEL_W1'(GRAVITY);
  localparam logic signed [VEL_W1-1:0] VY_MAX_S = VEL_W1'(VY_MAX_FALL);
  localparam logic signed [VEL_W-1:0]  VX_STEP  = VEL_W'(HSTEP);
  localparam logic [VEL_W1-1:0] CHARGE_STEP_U = VEL_W1'(CHARGE_STEP);
  localparam logic [VEL_W1-1:0] VJ_MAX_U      = VEL_W1'(VJ_MAX);
  localparam logic [LVL_W-1:0]  LVL_TOP       = LVL_W'(NUM_LEVELS - 1);

  localparam logic [2:0] SKIN_IDLE   = 3'd0;
  localparam logic [2:0] SKIN_CHARGE = 3'd1;
  localparam logic [2:0] SKIN_AIR    = 3'd2;
  localparam logic [2:0] SKIN_LEFT   = 3'd3;
  localparam logic [2:0] SKIN_RIGHT  = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_WALK_L, S_WALK_R, S_CHARGE, S_AIR} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          tick_cnt_q, tick_cnt_d;
  logic [ACC_W-1:0]          x_q, x_d, y_q, y_d;
  logic signed [VEL_W-1:0]   vy_q, vy_d, vx_q, vx_d;
  logic [VEL_W-1:0]          charge_q, charge_d;
  logic [CP_W-1:0]           cper_q, cper_d;
  logic [2:0]                skin_q, skin_d;
  logic                      facing_q, facing_d;
  logic [LVL_W-1:0]          level_q, level_d;

  logic                      tick_c, only_l_c, only_r_c, wall_hit_c;
  logic signed [VEL_W-1:0]   vy_eff_c, vy_next_c;
  logic signed [VEL_W1-1:0]  vy_grav_c;
  logic signed [SUM_W-1:0]   x_delta_c, x_sum_c, y_sum_c;
  logic [ACC_W-1:0]          x_clamp_c;
  logic [VEL_W1-1:0]         charge_sum_c;
  logic [VEL_W-1:0]          charge_sat_c;

  assign tick_c   = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
  assign only_l_c = bus.key_left & ~bus.key_right;
  assign only_r_c = bus.key_right & ~bus.key_left;

  // Shared arithmetic: x adder serves both walking and flight.
  assign x_delta_c  = (state_q == S_WALK_L) ? -HSTEP_FX :
                      (state_q == S_WALK_R) ?  HSTEP_FX : (SUM_W'(vx_q) <<< FRAC);
  assign x_sum_c    = $signed({1'b0, x_q}) + x_delta_c;
  assign x_clamp_c  = (x_sum_c < 0) ? '0 :
                      (x_sum_c > X_MAX_FX) ? ACC_W'(X_MAX_FX) : ACC_W'(x_sum_c);
  assign vy_eff_c   = (bus.col_top && vy_q[VEL_W-1]) ? '0 : vy_q;
  assign y_sum_c    = $signed({1'b0, y_q}) + SUM_W'(vy_eff_c);
  assign vy_grav_c  = VEL_W1'(vy_eff_c) + GRAV_S;
  assign vy_next_c  = (vy_grav_c > VY_MAX_S) ? VEL_W'(VY_MAX_S) : VEL_W'(vy_grav_c);
  assign wall_hit_c = (!vx_q[VEL_W-1] && (vx_q != '0) && bus.col_right) ||
                      (vx_q[VEL_W-1] && bus.col_left);
  assign charge_sum_c = VEL_W1'(charge_q) + CHARGE_STEP_U;
  assign charge_sat_c = (charge_sum_c > VJ_MAX_U) ? VEL_W'(VJ_MAX_U) : VEL_W'(charge_sum_c);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + CNT_W'(1);
    x_d        = x_q;
    y_d        = y_q;
    vy_d       = vy_q;
    vx_d       = vx_q;
    charge_d   = charge_q;
    cper_d     = cper_q;
    facing_d   = facing_q;
    level_d    = level_q;
    skin_d     = skin_q;

    case (state_q)
      S_IDLE, S_WALK_L, S_WALK_R: begin
        if (tick_c && ((state_q == S_WALK_L && !bus.col_left) ||
                       (state_q == S_WALK_R && !bus.col_right)))
          x_d = x_clamp_c;
        if (!bus.col_bot) begin
          state_d = S_AIR;
          vy_d    = '0;
          vx_d    = '0;
        end else if (bus.key_space) begin
          state_d  = S_CHARGE;
          charge_d = '0;
          cper_d   = '0;
        end else if (only_l_c) begin
          state_d  = S_WALK_L;
          facing_d = 1'b0;
        end else if (only_r_c) begin
          state_d  = S_WALK_R;
          facing_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CHARGE: begin
        if (!bus.key_space) begin
          state_d = S_AIR;
          vy_d    = -$signed(charge_q);
          vx_d    = only_l_c ? -VX_STEP : (only_r_c ? VX_STEP : '0);
          if (only_l_c || only_r_c) facing_d = only_r_c;
        end else if (tick_c) begin
          if (cper_q == CP_W'(CHARGE_TICKS - 1)) begin
            cper_d   = '0;
            charge_d = charge_sat_c;
          end else begin
            cper_d = cper_q + CP_W'(1);
          end
        end
      end

      S_AIR: begin
        if (tick_c) begin
          vy_d = vy_eff_c;
          if (bus.col_bot && !vy_eff_c[VEL_W-1]) begin
            state_d = S_IDLE;
            vy_d    = '0;
            vx_d    = '0;
            y_d     = y_q & INT_MASK;
          end else begin
            vy_d = vy_next_c;
            if (wall_hit_c) begin
`ifdef JK_WALL_BOUNCE_EN
              vx_d     = -vx_q;
              facing_d = vx_q[VEL_W-1];
`else
              vx_d     = '0;
`endif
            end else begin
              x_d = x_clamp_c;
            end
            // Leaving the top or bottom of the playfield pages to the adjacent level.
            if (y_sum_c < TOP_FX) begin
              if (level_q < LVL_TOP) begin
                level_d = level_q + LVL_W'(1);
                y_d     = Y_WRAP_UP;
              end else begin
                y_d  = '0;
                vy_d = '0;
              end
            end else if (y_sum_c >= BOT_LIM_FX) begin
              if (level_q != '0) begin
                level_d = level_q - LVL_W'(1);
                y_d     = Y_WRAP_DN;
              end else begin
                y_d = Y_FLOOR;
              end
            end else begin
              y_d = ACC_W'(y_sum_c);
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_WALK_L: skin_d = SKIN_LEFT;
      S_WALK_R: skin_d = SKIN_RIGHT;
      S_CHARGE: skin_d = SKIN_CHARGE;
      S_AIR:    skin_d = SKIN_AIR;
      default:  skin_d = SKIN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      x_q        <= X_RST;
      y_q        <= Y_RST;
      vy_q       <= '0;
      vx_q       <= '0;
      charge_q   <= '0;
      cper_q     <= '0;
      skin_q     <= SKIN_IDLE;
      facing_q   <= 1'b1;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vy_q       <= vy_d;
      vx_q       <= vx_d;
      charge_q   <= charge_d;
      cper_q     <= cper_d;
      skin_q     <= skin_d;
      facing_q   <= facing_d;
      level_q    <= level_d;
    end
  end

  assign bus.pos_x  = x_q[ACC_W-1:FRAC];
  assign bus.pos_y  = y_q[ACC_W-1:FRAC];
  assign bus.skin   = skin_q;
  assign bus.facing = facing_q;
  assign bus.level  = level_q;
endmodule

// File: tb/tb_jk_motion_ctl.sv
// tb_jk_motion_ctl: pixel-unit behavioural model checked every cycle, plus
// hand-computed waypoints for walking, charged jumps, level paging and wall hits.
module tb_jk_motion_ctl;
  localparam int M_IDLE = 0, M_WL = 1, M_WR = 2, M_CH = 3, M_AIR = 4;
  localparam int SUB = 16;          // sub-pixel units per pixel
  localparam int FLOOR_PX = 537;    // SCREEN_H - CHAR_H
`ifdef JK_WALL_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  jk_motion_if #(.POS_W(12), .LVL_W(3)) bus ();

  jk_motion_ctl #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit checking = 1'b0;

  // Model state: positions and velocities in 1/16 px.
  int m_mode = M_IDLE, m_x = 70 * SUB, m_y = 473 * SUB, m_vy = 0, m_vx = 0;
  int m_charge = 0, m_cper = 0, m_tc = 0, m_level = 0;
  bit m_facing = 1'b1;
  int m_ticks_in [5];

  function automatic int clampx(input int v);
    if (v < 0) return 0;
    if (v > 4095 * SUB) return 4095 * SUB;
    return v;
  endfunction

  function automatic int skin_of(input int mode);
    case (mode)
      M_WL:    return 3;
      M_WR:    return 4;
      M_CH:    return 1;
      M_AIR:   return 2;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic expire(input string what);
    n_checks++;
    $display("FAIL timeout %s: condition not reached at %0t", what, $time);
  endtask

  always @(posedge clk) begin : model
    bit tick, only_l, only_r, wall;
    if (rst) begin
      m_mode = M_IDLE; m_x = 70 * SUB; m_y = 473 * SUB; m_vy = 0; m_vx = 0;
      m_charge = 0; m_cper = 0; m_tc = 0; m_level = 0; m_facing = 1'b1;
    end else begin
      tick = (m_tc == 9);
      m_tc = tick ? 0 : m_tc + 1;
      if (tick) m_ticks_in[m_mode]++;
      only_l = bus.key_left && !bus.key_right;
      only_r = bus.key_right && !bus.key_left;
      case (m_mode)
        M_IDLE, M_WL, M_WR: begin
          if (tick && m_mode == M_WL && !bus.col_left)  m_x = clampx(m_x - 3 * SUB);
          if (tick && m_mode == M_WR && !bus.col_right) m_x = clampx(m_x + 3 * SUB);
          if (!bus.col_bot) begin m_mode = M_AIR; m_vy = 0; m_vx = 0; end
          else if (bus.key_space) begin m_mode = M_CH; m_charge = 0; m_cper = 0; end
          else if (only_l) begin m_mode = M_WL; m_facing = 1'b0; end
          else if (only_r) begin m_mode = M_WR; m_facing = 1'b1; end
          else m_mode = M_IDLE;
        end
        M_CH: begin
          if (!bus.key_space) begin
            m_mode = M_AIR;
            m_vy = -m_charge;
            m_vx = only_l ? -3 : (only_r ? 3 : 0);
            if (m_vx != 0) m_facing = (m_vx > 0);
          end else if (tick) begin
            m_cper++;
            if (m_cper == 3) begin
              m_cper = 0;
              m_charge = (m_charge + 8 > 160) ? 160 : m_charge + 8;
            end
          end
        end
        default: begin
          if (tick) begin
            if (bus.col_top && m_vy < 0) m_vy = 0;
            if (bus.col_bot && m_vy >= 0) begin
              m_mode = M_IDLE; m_vy = 0; m_vx = 0; m_y = (m_y / SUB) * SUB;
            end else begin
              m_y = m_y + m_vy;
              m_vy = (m_vy + 4 > 160) ? 160 : m_vy + 4;
              wall = (m_vx > 0 && bus.col_right) || (m_vx < 0 && bus.col_left);
              if (wall) begin
                if (BOUNCE) begin m_vx = -m_vx; m_facing = (m_vx > 0); end
                else m_vx = 0;
              end else m_x = clampx(m_x + m_vx * SUB);
              if (m_y < 5 * SUB) begin
                if (m_level < 4) begin m_level++; m_y = (FLOOR_PX - 5) * SUB; end
                else begin m_y = 0; m_vy = 0; end
              end else if (m_y >= (FLOOR_PX + 1) * SUB) begin
                if (m_level > 0) begin m_level--; m_y = 5 * SUB; end
                else m_y = FLOOR_PX * SUB;
              end
            end
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("pos_x",  int'(bus.pos_x),  m_x / SUB);
      check("pos_y",  int'(bus.pos_y),  m_y / SUB);
      check("skin",   int'(bus.skin),   skin_of(m_mode));
      check("facing", int'(bus.facing), int'(m_facing));
      check("level",  int'(bus.level),  m_level);
    end
  end

  task automatic wait_ticks_in(input int mode, input int n, input string what);
    int target = m_ticks_in[mode] + n;
    int guard = 0;
    while (m_ticks_in[mode] < target && guard < 5000) begin @(negedge clk); guard++; end
    if (m_ticks_in[mode] < target) expire(what);
  endtask

  task automatic hop(input int nticks, input bit l, input bit r);
    bus.col_bot = 1'b1;
    bus.key_space = 1'b1;
    wait_ticks_in(M_CH, nticks, "hop_charge");
    bus.key_space = 1'b0; bus.key_left = l; bus.key_right = r; bus.col_bot = 1'b0;
    @(negedge clk);
    bus.key_left = 1'b0; bus.key_right = 1'b0;
  endtask

  task automatic land_at_apex(input string what);
    int guard = 0;
    while (m_vy < 0 && guard < 5000) begin @(negedge clk); guard++; end
    if (m_vy < 0) expire(what);
    bus.col_bot = 1'b1;
    wait_ticks_in(M_AIR, 1, what);
  endtask

  task automatic wait_level(input int lvl, input string what);
    int guard = 0;
    while (m_level != lvl && guard < 5000) begin @(negedge clk); guard++; end
    if (m_level != lvl) expire(what);
  endtask

  initial begin
    int guard;
    bus.key_space = 1'b0; bus.key_left = 1'b0; bus.key_right = 1'b0;
    bus.col_left = 1'b0; bus.col_right = 1'b0; bus.col_top = 1'b0; bus.col_bot = 1'b1;
    @(negedge clk);
    checking = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle on the floor: nothing moves.
    repeat (100) @(negedge clk);
    check("rst_x", int'(bus.pos_x), 70);
    check("rst_y", int'(bus.pos_y), 473);
    check("rst_skin", int'(bus.skin), 0);
    check("rst_facing", int'(bus.facing), 1);
    check("rst_level", int'(bus.level), 0);

    // Walk right five ticks, then into a wall.
    bus.key_right = 1'b1;
    wait_ticks_in(M_WR, 5, "walk_right");
    check("walk_x", int'(bus.pos_x), 85);
    check("walk_skin", int'(bus.skin), 4);
    bus.col_right = 1'b1;
    wait_ticks_in(M_WR, 3, "walk_blocked");
    check("blocked_x", int'(bus.pos_x), 85);
    bus.key_right = 1'b0;
    @(negedge clk);
    bus.col_right = 1'b0;
    check("walk_stop_skin", int'(bus.skin), 0);

    // Charge 9 ticks (24), jump left, land at apex.
    bus.key_space = 1'b1;
    wait_ticks_in(M_CH, 9, "charge9");
    check("charge_skin", int'(bus.skin), 1);
    bus.key_space = 1'b0; bus.key_left = 1'b1; bus.col_bot = 1'b0;
    @(negedge clk);
    check("jump_skin", int'(bus.skin), 2);
    check("jump_facing", int'(bus.facing), 0);
    wait_ticks_in(M_AIR, 1, "jump_t1");
    check("jump_t1_y", int'(bus.pos_y), 471);
    check("jump_t1_x", int'(bus.pos_x), 82);
    bus.key_left = 1'b0;
    wait_ticks_in(M_AIR, 5, "jump_t6");
    bus.col_bot = 1'b1;
    wait_ticks_in(M_AIR, 1, "jump_land");
    check("land_skin", int'(bus.skin), 0);
    check("land_y", int'(bus.pos_y), 467);
    check("land_x", int'(bus.pos_x), 67);

    // Saturated charge jumps climb the screen and page up one level.
    hop(100, 1'b0, 1'b0);
    check("sat_facing", int'(bus.facing), 0);
    wait_ticks_in(M_AIR, 1, "sat_t1");
    check("sat_t1_y", int'(bus.pos_y), 457);
    land_at_apex("hop1");
    check("hop1_y", int'(bus.pos_y), 262);
    hop(100, 1'b0, 1'b0);
    land_at_apex("hop2");
    check("hop2_y", int'(bus.pos_y), 57);
    hop(100, 1'b0, 1'b0);
    wait_level(1, "level_up");
    check("lvl_up_level", int'(bus.level), 1);
    check("lvl_up_y", int'(bus.pos_y), 532);
    wait_level(0, "level_down");
    check("lvl_dn_level", int'(bus.level), 0);
    check("lvl_dn_y", int'(bus.pos_y), 5);
    guard = 0;
    while (m_y != FLOOR_PX * SUB && guard < 5000) begin @(negedge clk); guard++; end
    if (m_y != FLOOR_PX * SUB) expire("floor_clamp");
    check("floor_clamp_y", int'(bus.pos_y), 537);
    bus.col_bot = 1'b1;
    wait_ticks_in(M_AIR, 1, "floor_land");
    check("floor_land_skin", int'(bus.skin), 0);

    // Jump right into a wall, then bump the ceiling.
    hop(30, 1'b0, 1'b1);
    check("wall_jump_facing", int'(bus.facing), 1);
    wait_ticks_in(M_AIR, 2, "wall_pre");
    check("wall_pre_x", int'(bus.pos_x), 73);
    bus.col_right = 1'b1;
    wait_ticks_in(M_AIR, 1, "wall_hit");
    bus.col_right = 1'b0;
    check("wall_hit_x", int'(bus.pos_x), 73);
    check("wall_hit_facing", int'(bus.facing), BOUNCE ? 0 : 1);
    wait_ticks_in(M_AIR, 1, "wall_post");
    check("wall_post_x", int'(bus.pos_x), BOUNCE ? 70 : 73);
    bus.col_top = 1'b1;
    wait_ticks_in(M_AIR, 1, "ceiling");
    bus.col_top = 1'b0;
    check("ceiling_y", int'(bus.pos_y), 518);
    bus.col_bot = 1'b1;
    wait_ticks_in(M_AIR, 1, "ceiling_land");
    check("ceiling_land_skin", int'(bus.skin), 0);
    check("ceiling_land_y", int'(bus.pos_y), 518);

    // Reset in mid-air discards momentum and position.
    hop(9, 1'b1, 1'b0);
    wait_ticks_in(M_AIR, 2, "midair");
    rst = 1'b1;
    bus.col_bot = 1'b1;
    @(negedge clk);
    check("mid_rst_x", int'(bus.pos_x), 70);
    check("mid_rst_y", int'(bus.pos_y), 473);
    check("mid_rst_skin", int'(bus.skin), 0);
    check("mid_rst_facing", int'(bus.facing), 1);
    check("mid_rst_level", int'(bus.level), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("post_rst_y", int'(bus.pos_y), 473);

    checking = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
